// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of the single-port 32-bit instruction/data
// RAM. It issues sequential word reads, catches the read data one cycle later
// in a small show-ahead prefetch FIFO, and presents {instruction, word address}
// to decode over a valid/ready handshake. A redirect pulse from branch/jump
// resolution flushes everything buffered or in flight and restarts fetch at
// the target address.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   -> stall_cnt counts cycles where inst_valid=1 and inst_ready=0
//                (saturating at 16'hFFFF, cleared only by reset)
//   undefined -> stall_cnt is tied to zero and no counter exists
//
// Ports
//   clock           in   system clock, all logic on posedge
//   reset_n         in   asynchronous active-low reset
//   fetch_en        in   permits new RAM reads while high
//   redirect_valid  in   one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     in   redirect target word address
//   mem_addr        out  RAM word address (registered)
//   mem_rd          out  RAM read strobe (registered)
//   mem_rdata       in   RAM read data, valid the cycle after mem_rd
//   inst_valid      out  FIFO head holds an instruction
//   inst_ready      in   decode accepts the head this cycle
//   inst_data       out  head instruction (zero when empty)
//   inst_pc         out  head word address (zero when empty)
//   stall_cnt       out  decode back-pressure counter (see macro above)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [15:0]       stall_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    // Fetch / RAM-port state
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_issued_addr;
    logic              r_mem_rd;

    // Prefetch FIFO
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [CNT_W:0]    w_occ;

    assign w_valid = (r_count != '0);

    // A redirect discards the word returning this cycle and ignores any pop.
    assign w_push = r_mem_rd && !redirect_valid;
    assign w_pop  = w_valid && inst_ready && !redirect_valid;

    // Reserve a slot for the read still in flight; counting occupancy before
    // this edge's pop keeps the FIFO from ever overflowing.
    assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_mem_rd};
    assign w_issue = fetch_en && !redirect_valid && (w_occ < DEPTH_V);

    // ------------------------------------------------------------------
    // RAM read issue
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_ADDR;
            r_mem_addr    <= RESET_ADDR;
            r_issued_addr <= RESET_ADDR;
            r_mem_rd      <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_mem_rd <= 1'b0;
        end else if (w_issue) begin
            r_mem_addr    <= r_pc;
            r_issued_addr <= r_pc;
            r_mem_rd      <= 1'b1;
            r_pc          <= r_pc + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        end else begin
            r_mem_rd <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage carries no reset; the outputs are masked while empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_issued_addr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign inst_valid = w_valid;
    assign inst_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign inst_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_valid && !inst_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit: directed, table-driven bench for fetch_unit with a
// behavioural RAM (samples addr/rd on negedge, data valid at next posedge).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [8:0]  redirect_pc = 9'h000;
    logic [8:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [8:0]  inst_pc;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    logic [8:0] next_exp_pc;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .stall_cnt      (stall_cnt)
    );

    // RAM contents: four fixed words, then an address-tagged pattern.
    function automatic logic [31:0] ram_word(input logic [8:0] a);
        case (a)
            9'd0:    return 32'h2245_0000;
            9'd1:    return 32'h10F0_0010;
            9'd2:    return 32'h0000_000A;
            9'd3:    return 32'h0000_000B;
            default: return 32'h5A00_0000 | {23'd0, a};
        endcase
    endfunction

    // Junk pattern when not reading, so stray sampling shows up.
    always @(negedge clock) begin
        if (mem_rd) mem_rdata <= ram_word(mem_addr);
        else        mem_rdata <= 32'hDEAD_BEEF;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) step();
        chk("rst_mem_rd",     {31'd0, mem_rd},     32'd0);
        chk("rst_mem_addr",   {23'd0, mem_addr},   32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_data",  inst_data,           32'd0);
        chk("rst_inst_pc",    {23'd0, inst_pc},    32'd0);
        chk("rst_stall_cnt",  {16'd0, stall_cnt},  32'd0);
        reset_n = 1'b1;
    endtask

    // Record the current head as the next expected output (if valid).
    task automatic consume_if_valid();
        if (inst_valid) begin
            chk("out_pc",   {23'd0, inst_pc}, {23'd0, next_exp_pc});
            chk("out_data", inst_data, ram_word(next_exp_pc));
            $display("out pc=%h data=%h", inst_pc, inst_data);
            next_exp_pc = next_exp_pc + 9'd1;
        end
    endtask

    // Wait (bounded) for one output with inst_ready=1 and check it.
    task automatic get_out();
        bit got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (inst_valid) begin
                consume_if_valid();
                got = 1'b1;
            end
            step();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: no output, want pc %h", next_exp_pc);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rdy;
        logic        exp_rd;
        logic [8:0]  exp_addr;
        logic        exp_v;
        logic [31:0] exp_data;
        logic [8:0]  exp_pc;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs [16];

    initial begin
        // Rows: inputs applied before an edge, outputs expected after it.
        // Stream with decode always ready.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 9'd0, 1'b0, 32'h0000_0000, 9'd0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd1, 1'b1, 32'h2245_0000, 9'd0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd2, 1'b1, 32'h10F0_0010, 9'd1, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd3, 1'b1, 32'h0000_000A, 9'd2, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd4, 1'b1, 32'h0000_000B, 9'd3, 16'd0};
        // Decode stalled from reset: FIFO fills to DEPTH, then resumes.
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 9'd0, 1'b0, 32'h0000_0000, 9'd0, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 9'd1, 1'b1, 32'h2245_0000, 9'd0, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 9'd2, 1'b1, 32'h2245_0000, 9'd0, 16'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 9'd3, 1'b1, 32'h2245_0000, 9'd0, 16'd2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9'd3, 1'b1, 32'h2245_0000, 9'd0, 16'd3};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 9'd3, 1'b1, 32'h2245_0000, 9'd0, 16'd4};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 9'd3, 1'b1, 32'h10F0_0010, 9'd1, 16'd4};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd4, 1'b1, 32'h0000_000A, 9'd2, 16'd4};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd5, 1'b1, 32'h0000_000B, 9'd3, 16'd4};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd6, 1'b1, 32'h5A00_0004, 9'd4, 16'd4};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 9'd7, 1'b1, 32'h5A00_0005, 9'd5, 16'd4};

        for (int i = 0; i < 16; i++) begin
            logic [15:0] want_stall;
`ifdef FETCH_PERF_CNT_EN
            want_stall = vecs[i].exp_stall;
`else
            want_stall = 16'h0000;
`endif
            if (vecs[i].rst) do_reset();
            fetch_en   = vecs[i].fe;
            inst_ready = vecs[i].rdy;
            step();
            chk($sformatf("row%0d_mem_rd", i),   {31'd0, mem_rd},     {31'd0, vecs[i].exp_rd});
            chk($sformatf("row%0d_mem_addr", i), {23'd0, mem_addr},   {23'd0, vecs[i].exp_addr});
            chk($sformatf("row%0d_valid", i),    {31'd0, inst_valid}, {31'd0, vecs[i].exp_v});
            chk($sformatf("row%0d_data", i),     inst_data,           vecs[i].exp_data);
            chk($sformatf("row%0d_pc", i),       {23'd0, inst_pc},    {23'd0, vecs[i].exp_pc});
            chk($sformatf("row%0d_stall", i),    {16'd0, stall_cnt},  {16'd0, want_stall});
            $display("row %0d: rd=%b addr=%h v=%b data=%h pc=%h stall=%0d",
                     i, mem_rd, mem_addr, inst_valid, inst_data, inst_pc, stall_cnt);
        end

        // Redirect with 3 words buffered and a 4th read in flight.
        do_reset();
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        repeat (4) step();
        chk("redir_pre_rd", {31'd0, mem_rd}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 9'h040;
        step();
        redirect_valid = 1'b0;
        chk("redir_valid_n1", {31'd0, inst_valid}, 32'd0);
        chk("redir_rd_n1",    {31'd0, mem_rd},     32'd0);
        step();
        chk("redir_rd_n2",    {31'd0, mem_rd},     32'd1);
        chk("redir_addr_n2",  {23'd0, mem_addr},   32'h040);
        chk("redir_valid_n2", {31'd0, inst_valid}, 32'd0);
        step();
        chk("redir_valid_n3", {31'd0, inst_valid}, 32'd1);
        $display("redirect: first head pc=%h data=%h", inst_pc, inst_data);
        inst_ready  = 1'b1;
        next_exp_pc = 9'h040;
        repeat (3) get_out();

        // Wrap from the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 9'h1FF;
        step();
        redirect_valid = 1'b0;
        chk("wrap_flush_valid", {31'd0, inst_valid}, 32'd0);
        next_exp_pc = 9'h1FF;
        repeat (3) get_out();

        // fetch_en low for 5 edges mid-stream: no new reads, stream continues.
        fetch_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            consume_if_valid();
            step();
            chk($sformatf("fe_off_rd%0d", k), {31'd0, mem_rd}, 32'd0);
        end
        fetch_en = 1'b1;
        repeat (4) get_out();

        // Stall counter: decode held off for 12 edges after reset.
        do_reset();
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        repeat (12) step();
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt_10", {16'd0, stall_cnt}, 32'd10);
`else
        chk("stall_cnt_0", {16'd0, stall_cnt}, 32'd0);
`endif
        $display("stall test: stall_cnt=%0d", stall_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
